pixel_scan_gen: RTL and testbench

- Parametrised pixel-coordinate sequencer; successor to the single-mode position counter.
- Walks a configurable region of interest (ROI) with programmable stride in raster, serpentine or column order.
- Presents each coordinate on a valid/ready stream, with a direction hint, last flag and completion pulse.
- Sits between the frame controller and the window-fetch / FAST corner pipeline.

---
 rtl/pixel_scan_pkg.sv | 27 ++
 rtl/pixel_scan_gen_if.sv | 25 ++
 rtl/pixel_scan_gen_extent.sv | 96 +++++++++
 rtl/pixel_scan_gen.sv | 261 ++++++++++++++++++++++++++
 tb/tb_pixel_scan_gen.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_scan_pkg.sv
// Shared types and default sizing for the pixel scan sequencer.
package pixel_scan_pkg;

  localparam int unsigned DEF_X_MAX  = 640;
  localparam int unsigned DEF_Y_MAX  = 480;
  localparam int unsigned DEF_STEP_W = 4;

  typedef enum logic [1:0] {
    RASTER     = 2'd0,
    SERPENTINE = 2'd1,
    COLUMN     = 2'd2,
    RSVD       = 2'd3
  } scan_mode_t;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_NONE  = 2'b11
  } dir_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/pixel_scan_gen_if.sv
// Coordinate stream from the scan sequencer to the window-fetch consumer.
interface pixel_scan_gen_if #(
  parameter int unsigned X_W = 10,
  parameter int unsigned Y_W = 9
);
  import pixel_scan_pkg::*;

  logic           pos_valid;
  logic           pos_ready;
  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
  logic           pos_last;
  dir_t           next_dir;

  modport master (
    output pos_valid, pos_x, pos_y, pos_last, next_dir,
    input  pos_ready
  );

  modport slave (
    input  pos_valid, pos_x, pos_y, pos_last, next_dir,
    output pos_ready
  );

endinterface

// File: rtl/pixel_scan_gen_extent.sv
// Computes the last reachable x/y on the stride grid by repeated subtraction.
module scan_extent_calc #(
  parameter int unsigned X_W    = 10,
  parameter int unsigned Y_W    = 9,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [X_W-1:0]    x0_i,
  input  logic [X_W-1:0]    x1_i,
  input  logic [STEP_W-1:0] sx_i,
  input  logic [Y_W-1:0]    y0_i,
  input  logic [Y_W-1:0]    y1_i,
  input  logic [STEP_W-1:0] sy_i,
  output logic [X_W-1:0]    xe_o,
  output logic [Y_W-1:0]    ye_o,
  output logic              valid_o
);

  logic              run_q, run_d;
  logic              valid_q, valid_d;
  logic [X_W:0]      rem_x_q, rem_x_d, acc_x_q, acc_x_d;
  logic [Y_W:0]      rem_y_q, rem_y_d, acc_y_q, acc_y_d;
  logic [STEP_W-1:0] sx_q, sx_d, sy_q, sy_d;
  logic              adv_x_c, adv_y_c, fin_c;

  assign adv_x_c = rem_x_q >= (X_W+1)'(sx_q);
  assign adv_y_c = rem_y_q >= (Y_W+1)'(sy_q);
  assign fin_c   = run_q && !adv_x_c && !adv_y_c;

  // Load a new job, or step both remainders until neither can take another stride.
  always_comb begin
    run_d   = run_q;
    valid_d = 1'b0;
    rem_x_d = rem_x_q;
    acc_x_d = acc_x_q;
    rem_y_d = rem_y_q;
    acc_y_d = acc_y_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    if (clear_i) begin
      run_d = 1'b0;
    end else if (load_i) begin
      run_d   = 1'b1;
      rem_x_d = {1'b0, x1_i} - {1'b0, x0_i};
      acc_x_d = {1'b0, x0_i};
      rem_y_d = {1'b0, y1_i} - {1'b0, y0_i};
      acc_y_d = {1'b0, y0_i};
      sx_d    = sx_i;
      sy_d    = sy_i;
    end else if (run_q) begin
      if (fin_c) begin
        run_d   = 1'b0;
        valid_d = 1'b1;
      end
      if (adv_x_c) begin
        rem_x_d = rem_x_q - (X_W+1)'(sx_q);
        acc_x_d = acc_x_q + (X_W+1)'(sx_q);
      end
      if (adv_y_c) begin
        rem_y_d = rem_y_q - (Y_W+1)'(sy_q);
        acc_y_d = acc_y_q + (Y_W+1)'(sy_q);
      end
    end
  end

  // Extent calculator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= 1'b0;
      valid_q <= 1'b0;
      rem_x_q <= '0;
      acc_x_q <= '0;
      rem_y_q <= '0;
      acc_y_q <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
    end else begin
      run_q   <= run_d;
      valid_q <= valid_d;
      rem_x_q <= rem_x_d;
      acc_x_q <= acc_x_d;
      rem_y_q <= rem_y_d;
      acc_y_q <= acc_y_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
    end
  end

  assign xe_o    = X_W'(acc_x_q);
  assign ye_o    = Y_W'(acc_y_q);
  assign valid_o = valid_q;

endmodule

// File: rtl/pixel_scan_gen.sv
// ROI coordinate sequencer: raster, serpentine or column walk with stride.
module pixel_scan_gen
  import pixel_scan_pkg::*;
#(
  parameter  int unsigned X_MAX  = DEF_X_MAX,
  parameter  int unsigned Y_MAX  = DEF_Y_MAX,
  parameter  int unsigned STEP_W = DEF_STEP_W,
  localparam int unsigned X_W    = $clog2(X_MAX),
  localparam int unsigned Y_W    = $clog2(Y_MAX)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [1:0]              cfg_mode,
  input  logic [X_W-1:0]          cfg_x0,
  input  logic [Y_W-1:0]          cfg_y0,
  input  logic [X_W-1:0]          cfg_x1,
  input  logic [Y_W-1:0]          cfg_y1,
  input  logic [STEP_W-1:0]       cfg_step_x,
  input  logic [STEP_W-1:0]       cfg_step_y,
  pixel_scan_gen_if.master        pos,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
);

  scan_state_t       state_q, state_d;
  scan_mode_t        mode_q, mode_d;
  logic [X_W-1:0]    x0_q, x0_d, pos_x_q, pos_x_d;
  logic [Y_W-1:0]    y0_q, y0_d, pos_y_q, pos_y_d;
  logic [STEP_W-1:0] sx_q, sx_d, sy_q, sy_d;
  logic              odd_q, odd_d, calc_q, calc_d;
  logic              pos_valid_q, pos_valid_d, pos_last_q, pos_last_d;
  dir_t              next_dir_q, next_dir_d;
  logic              busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;

  logic              cfg_ok_c, accept_c, xfer_c, ext_valid;
  logic [X_W-1:0]    xe, succ_x, cand_x;
  logic [Y_W-1:0]    ye, succ_y, cand_y;
  logic              succ_odd, cand_odd, cand_last;
  dir_t              cand_dir;
  logic [X_W:0]      x_up_c, x_dn_c;
  logic [Y_W:0]      y_up_c;

  assign cfg_ok_c = (cfg_x0 <= cfg_x1) && (cfg_y0 <= cfg_y1) &&
                    (cfg_step_x != '0) && (cfg_step_y != '0) &&
                    (scan_mode_t'(cfg_mode) != RSVD);
  assign accept_c = (state_q == ST_IDLE) && start && cfg_ok_c;
  assign xfer_c   = pos_valid_q && pos.pos_ready;

  scan_extent_calc #(
    .X_W    (X_W),
    .Y_W    (Y_W),
    .STEP_W (STEP_W)
  ) u_extent (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept_c),
    .clear_i ((state_q == ST_SCAN) && abort),
    .x0_i    (cfg_x0),
    .x1_i    (cfg_x1),
    .sx_i    (cfg_step_x),
    .y0_i    (cfg_y0),
    .y1_i    (cfg_y1),
    .sy_i    (cfg_step_y),
    .xe_o    (xe),
    .ye_o    (ye),
    .valid_o (ext_valid)
  );

  // Stride arithmetic one bit wider than the coordinate fields.
  assign x_up_c = {1'b0, pos_x_q} + (X_W+1)'(sx_q);
  assign x_dn_c = {1'b0, pos_x_q} - (X_W+1)'(sx_q);
  assign y_up_c = {1'b0, pos_y_q} + (Y_W+1)'(sy_q);

  // Successor of the current coordinate, following the already-published direction.
  always_comb begin
    succ_x   = pos_x_q;
    succ_y   = pos_y_q;
    succ_odd = odd_q;
    case (next_dir_q)
      DIR_RIGHT: begin
        succ_x = X_W'(x_up_c);
        if (mode_q == COLUMN) succ_y = y0_q;
      end
      DIR_LEFT:  succ_x = X_W'(x_dn_c);
      DIR_DOWN: begin
        succ_y   = Y_W'(y_up_c);
        succ_odd = ~odd_q;
        if (mode_q == RASTER) succ_x = x0_q;
      end
      default: ;
    endcase
  end

  // Next coordinate to publish plus its last flag and outgoing direction.
  always_comb begin
    cand_x    = calc_q ? x0_q : succ_x;
    cand_y    = calc_q ? y0_q : succ_y;
    cand_odd  = calc_q ? 1'b0 : succ_odd;
    cand_last = 1'b0;
    cand_dir  = DIR_RIGHT;
    case (mode_q)
      SERPENTINE: begin
        if (cand_odd) begin
          cand_last = (cand_x == x0_q) && (cand_y == ye);
          cand_dir  = (cand_x == x0_q) ? DIR_DOWN : DIR_LEFT;
        end else begin
          cand_last = (cand_x == xe) && (cand_y == ye);
          cand_dir  = (cand_x == xe) ? DIR_DOWN : DIR_RIGHT;
        end
      end
      COLUMN: begin
        cand_last = (cand_x == xe) && (cand_y == ye);
        cand_dir  = (cand_y == ye) ? DIR_RIGHT : DIR_DOWN;
      end
      default: begin
        cand_last = (cand_x == xe) && (cand_y == ye);
        cand_dir  = (cand_x == xe) ? DIR_DOWN : DIR_RIGHT;
      end
    endcase
    if (cand_last) cand_dir = DIR_NONE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: abort wins over the final transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c) state_d = ST_SCAN;
      ST_SCAN: if (abort || (xfer_c && pos_last_q)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    mode_d      = mode_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    odd_d       = odd_q;
    calc_d      = calc_q;
    pos_valid_d = pos_valid_q;
    pos_last_d  = pos_last_q;
    next_dir_d  = next_dir_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok_c) begin
            mode_d      = scan_mode_t'(cfg_mode);
            x0_d        = cfg_x0;
            y0_d        = cfg_y0;
            sx_d        = cfg_step_x;
            sy_d        = cfg_step_y;
            calc_d      = 1'b1;
            busy_d      = 1'b1;
            pos_valid_d = 1'b0;
            pos_last_d  = 1'b0;
            next_dir_d  = DIR_NONE;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (abort) begin
          calc_d      = 1'b0;
          busy_d      = 1'b0;
          pos_valid_d = 1'b0;
          pos_last_d  = 1'b0;
          next_dir_d  = DIR_NONE;
        end else if (calc_q) begin
          if (ext_valid) begin
            calc_d      = 1'b0;
            pos_valid_d = 1'b1;
            pos_x_d     = cand_x;
            pos_y_d     = cand_y;
            odd_d       = cand_odd;
            pos_last_d  = cand_last;
            next_dir_d  = cand_dir;
          end
        end else if (xfer_c) begin
          if (pos_last_q) begin
            busy_d      = 1'b0;
            done_d      = 1'b1;
            pos_valid_d = 1'b0;
            pos_last_d  = 1'b0;
            next_dir_d  = DIR_NONE;
          end else begin
            pos_x_d    = cand_x;
            pos_y_d    = cand_y;
            odd_d      = cand_odd;
            pos_last_d = cand_last;
            next_dir_d = cand_dir;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= RASTER;
      x0_q        <= '0;
      y0_q        <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      odd_q       <= 1'b0;
      calc_q      <= 1'b0;
      pos_valid_q <= 1'b0;
      pos_last_q  <= 1'b0;
      next_dir_q  <= DIR_RIGHT;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      odd_q       <= odd_d;
      calc_q      <= calc_d;
      pos_valid_q <= pos_valid_d;
      pos_last_q  <= pos_last_d;
      next_dir_q  <= next_dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign pos.pos_valid = pos_valid_q;
  assign pos.pos_x     = pos_x_q;
  assign pos.pos_y     = pos_y_q;
  assign pos.pos_last  = pos_last_q;
  assign pos.next_dir  = next_dir_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_pixel_scan_gen.sv
// Bench for pixel_scan_gen: directed cases plus random ROIs against a loop-based model.
module tb_pixel_scan_gen;
  import pixel_scan_pkg::*;

  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 9;
  localparam int unsigned STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst, start, abort;
  logic [1:0]        cfg_mode;
  logic [X_W-1:0]    cfg_x0, cfg_x1;
  logic [Y_W-1:0]    cfg_y0, cfg_y1;
  logic [STEP_W-1:0] cfg_step_x, cfg_step_y;
  logic              busy, done, cfg_err;

  pixel_scan_gen_if #(.X_W(X_W), .Y_W(Y_W)) pos_if ();

  pixel_scan_gen #(.X_MAX(640), .Y_MAX(480), .STEP_W(STEP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cfg_mode   (cfg_mode),
    .cfg_x0     (cfg_x0),
    .cfg_y0     (cfg_y0),
    .cfg_x1     (cfg_x1),
    .cfg_y1     (cfg_y1),
    .cfg_step_x (cfg_step_x),
    .cfg_step_y (cfg_step_y),
    .pos        (pos_if),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   x;
    int   y;
    logic last;
    int   dir;
  } coord_t;

  coord_t exp_q[$];
  int     n_chk  = 0;
  int     n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected visit order from nested loops; direction derived from the step to the next point.
  task automatic build_model(input int mode, input int x0, input int y0, input int x1,
                             input int y1, input int sx, input int sy);
    int     xs[$];
    int     row;
    coord_t c;
    exp_q.delete();
    row = 0;
    if (mode == 2) begin
      for (int x = x0; x <= x1; x += sx)
        for (int y = y0; y <= y1; y += sy) begin
          c.x = x; c.y = y; c.last = 1'b0; c.dir = 3;
          exp_q.push_back(c);
        end
    end else begin
      for (int y = y0; y <= y1; y += sy) begin
        xs.delete();
        for (int x = x0; x <= x1; x += sx) xs.push_back(x);
        if (mode == 1 && (row % 2) == 1) xs.reverse();
        foreach (xs[i]) begin
          c.x = xs[i]; c.y = y; c.last = 1'b0; c.dir = 3;
          exp_q.push_back(c);
        end
        row++;
      end
    end
    for (int i = 0; i < int'(exp_q.size()); i++) begin
      c = exp_q[i];
      if (i == int'(exp_q.size()) - 1) begin
        c.last = 1'b1; c.dir = 3;
      end else if (exp_q[i+1].y > c.y) c.dir = 2;
      else if (exp_q[i+1].x > c.x)     c.dir = 0;
      else                              c.dir = 1;
      exp_q[i] = c;
    end
  endtask

  task automatic drive_cfg(input int mode, input int x0, input int y0, input int x1,
                           input int y1, input int sx, input int sy);
    cfg_mode   = 2'(mode);
    cfg_x0     = X_W'(x0);
    cfg_y0     = Y_W'(y0);
    cfg_x1     = X_W'(x1);
    cfg_y1     = Y_W'(y1);
    cfg_step_x = STEP_W'(sx);
    cfg_step_y = STEP_W'(sy);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, pos_if.pos_valid, 0);
    chk({tag, "_x"}, pos_if.pos_x, 0);
    chk({tag, "_y"}, pos_if.pos_y, 0);
    chk({tag, "_last"}, pos_if.pos_last, 0);
    chk({tag, "_dir"}, pos_if.next_dir, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  // rdy_mode: 0 always ready, 1 toggling, 2 random. abort_after < 0 runs to completion.
  // chain leaves the bench in the done cycle so the next start lands there.
  task automatic run_scan(input string tag, input int mode, input int x0, input int y0,
                          input int x1, input int y1, input int sx, input int sy,
                          input int rdy_mode, input int abort_after, input bit chain);
    int   idx, lat;
    logic rdy, stalled, saw_last;
    int   sv_x, sv_y, sv_last, sv_dir;
    build_model(mode, x0, y0, x1, y1, sx, sy);
    drive_cfg(mode, x0, y0, x1, y1, sx, sy);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    lat = 0;
    while (!pos_if.pos_valid && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_first_valid"}, pos_if.pos_valid, 1);
    idx = 0; stalled = 1'b0; saw_last = 1'b0;
    sv_x = 0; sv_y = 0; sv_last = 0; sv_dir = 0;
    for (int cyc = 0; cyc < 20000 && !saw_last && !(abort_after >= 0 && idx == abort_after); cyc++) begin
      if (stalled) begin
        chk({tag, "_hold_valid"}, pos_if.pos_valid, 1);
        chk({tag, "_hold_x"}, pos_if.pos_x, sv_x);
        chk({tag, "_hold_y"}, pos_if.pos_y, sv_y);
        chk({tag, "_hold_last"}, pos_if.pos_last, sv_last);
        chk({tag, "_hold_dir"}, pos_if.next_dir, sv_dir);
      end
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2) == 1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      pos_if.pos_ready = rdy;
      if (pos_if.pos_valid && rdy) begin
        if (idx < int'(exp_q.size())) begin
          chk({tag, "_x"}, pos_if.pos_x, exp_q[idx].x);
          chk({tag, "_y"}, pos_if.pos_y, exp_q[idx].y);
          chk({tag, "_last"}, pos_if.pos_last, exp_q[idx].last);
          chk({tag, "_dir"}, pos_if.next_dir, exp_q[idx].dir);
        end else begin
          chk({tag, "_overrun"}, idx, exp_q.size());
        end
        saw_last = pos_if.pos_last;
        idx++;
      end
      stalled = pos_if.pos_valid && !rdy;
      sv_x = int'(pos_if.pos_x); sv_y = int'(pos_if.pos_y);
      sv_last = int'(pos_if.pos_last); sv_dir = int'(pos_if.next_dir);
      @(posedge clk); #1;
    end
    pos_if.pos_ready = 1'b0;
    if (abort_after >= 0) begin
      chk({tag, "_abort_idx"}, idx, abort_after);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk({tag, "_abort_valid"}, pos_if.pos_valid, 0);
      chk({tag, "_abort_busy"}, busy, 0);
      chk({tag, "_abort_done"}, done, 0);
      chk({tag, "_abort_hold_x"}, pos_if.pos_x, exp_q[abort_after].x);
      chk({tag, "_abort_hold_y"}, pos_if.pos_y, exp_q[abort_after].y);
      @(posedge clk); #1;
      chk({tag, "_abort_done2"}, done, 0);
    end else begin
      chk({tag, "_count"}, idx, exp_q.size());
      chk({tag, "_done"}, done, 1);
      chk({tag, "_end_valid"}, pos_if.pos_valid, 0);
      chk({tag, "_end_busy"}, busy, 0);
      chk({tag, "_end_dir"}, pos_if.next_dir, 3);
      if (!chain) begin
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 0);
      end
    end
  endtask

  task automatic err_start(input string tag, input int mode, input int x0, input int y0,
                           input int x1, input int y1, input int sx, input int sy);
    drive_cfg(mode, x0, y0, x1, y1, sx, sy);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_cfg_err"}, cfg_err, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, pos_if.pos_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_cfg_err_pulse"}, cfg_err, 0);
    chk({tag, "_busy2"}, busy, 0);
    chk({tag, "_valid2"}, pos_if.pos_valid, 0);
  endtask

  initial begin
    int m, x0, y0, x1, y1, sx, sy;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    pos_if.pos_ready = 1'b0;
    drive_cfg(0, 0, 0, 0, 0, 1, 1);
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_scan("raster", 0, 2, 1, 8, 5, 2, 2, 0, -1, 1'b0);
    run_scan("serp", 1, 0, 0, 4, 2, 1, 1, 1, -1, 1'b1);
    run_scan("column", 2, 0, 0, 2, 3, 1, 3, 2, -1, 1'b0);

    err_start("err_x0gtx1", 0, 9, 0, 3, 4, 1, 1);
    err_start("err_stepx0", 0, 0, 0, 5, 5, 0, 1);
    err_start("err_mode3", 3, 0, 0, 5, 5, 1, 1);
    err_start("err_y0gty1", 1, 0, 7, 5, 2, 1, 1);

    run_scan("abort10", 0, 0, 0, 9, 9, 1, 1, 2, 5, 1'b0);
    run_scan("single", 0, 5, 5, 5, 5, 1, 1, 0, -1, 1'b0);

    // Reset in the middle of a scan.
    drive_cfg(0, 0, 0, 9, 9, 1, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 200 && !pos_if.pos_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("midrst_pre_valid", pos_if.pos_valid, 1);
    pos_if.pos_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero("midrst");
    rst = 1'b0;
    pos_if.pos_ready = 1'b0;
    @(posedge clk); #1;
    chk("midrst_no_done", done, 0);
    run_scan("restart", 1, 3, 2, 9, 7, 3, 2, 2, -1, 1'b0);

    for (int k = 0; k < 12; k++) begin
      m  = int'($urandom_range(0, 2));
      x0 = int'($urandom_range(0, 600));
      y0 = int'($urandom_range(0, 450));
      x1 = x0 + int'($urandom_range(0, 20));
      y1 = y0 + int'($urandom_range(0, 20));
      sx = int'($urandom_range(1, 15));
      sy = int'($urandom_range(1, 15));
      run_scan("rand", m, x0, y0, x1, y1, sx, sy, 2, -1, (k % 2) == 1);
    end
    run_scan("corner", 1, 620, 460, 639, 479, 3, 4, 2, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
